// File: rtl/exec_pkg.sv
// Shared codes and enums for the multi-cycle execute stage.
package exec_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_FUNC = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_MULTU, ALU_DIVU, ALU_MFHI, ALU_MFLO, ALU_ZERO
    } alu_ctrl_e;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_HOLD} state_e;

endpackage

// File: rtl/execute_unit_mc_if.sv
// Handshake and operand/result bundle between decode, execute and memory stages.
interface execute_unit_mc_if #(parameter int unsigned DATA_W = 32);

    logic              In_Valid;
    logic              In_Ready;
    logic [DATA_W-1:0] ALU_Read_DataOne;
    logic [DATA_W-1:0] ALU_Read_DataTwo;
    logic [DATA_W-1:0] Immediate;
    logic [5:0]        Function;
    logic [2:0]        ALU_Operation;
    logic              ALU_Source;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [DATA_W-1:0] ALU_Result;
    logic              Zero;
    logic              Busy;

    modport master (
        output In_Valid, ALU_Read_DataOne, ALU_Read_DataTwo, Immediate, Function,
               ALU_Operation, ALU_Source, Out_Ready,
        input  In_Ready, Out_Valid, ALU_Result, Zero, Busy
    );

    modport slave (
        input  In_Valid, ALU_Read_DataOne, ALU_Read_DataTwo, Immediate, Function,
               ALU_Operation, ALU_Source, Out_Ready,
        output In_Ready, Out_Valid, ALU_Result, Zero, Busy
    );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
module muldiv_iter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done_c,
    output logic [DATA_W-1:0] lo_fin_c,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    logic [CNT_W-1:0]  cnt_q;
    logic              div_q;
    logic [DATA_W-1:0] acc_q, low_q, opb_q;
    logic [DATA_W:0]   sum_c, rsh_c;
    logic [DATA_W-1:0] diff_c, acc_n, low_n;
    logic              ge_c;

    // acc/low hold product-high/multiplier for multu and remainder/dividend-quotient for divu
    always_comb begin
        sum_c  = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : '0);
        rsh_c  = {acc_q, low_q[DATA_W-1]};
        ge_c   = rsh_c >= {1'b0, opb_q};
        diff_c = rsh_c[DATA_W-1:0] - opb_q;
        if (div_q) begin
            acc_n = ge_c ? diff_c : rsh_c[DATA_W-1:0];
            low_n = {low_q[DATA_W-2:0], ge_c};
        end else begin
            acc_n = sum_c[DATA_W:1];
            low_n = {sum_c[0], low_q[DATA_W-1:1]};
        end
    end

    assign done_c   = (cnt_q == CNT_W'(1));
    assign lo_fin_c = low_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= 1'b0;
            acc_q <= '0;
            low_q <= '0;
            opb_q <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (start) begin
            cnt_q <= CNT_W'(DATA_W);
            div_q <= op_div;
            acc_q <= '0;
            low_q <= a;
            opb_q <= b;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            acc_q <= acc_n;
            low_q <= low_n;
            if (done_c) begin
                hi <= acc_n;
                lo <= low_n;
            end
        end
    end

endmodule

// File: rtl/execute_unit_mc.sv
// Multi-cycle execute stage with valid/ready handshakes.
// Define EXEC_MULDIV_EN to build the iterative multu/divu unit and HI/LO registers.
module execute_unit_mc
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input logic             clockPulse,
    input logic             resetN,
    execute_unit_mc_if.slave bus
);

    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    state_e            state_q, state_d;
    alu_ctrl_e         ctrl_c;
    logic [DATA_W-1:0] b_c, alu_c, result_q, result_d;
    logic [SHAMT_W-1:0] shamt_c;
    logic              zero_q, zero_d, valid_q, valid_d, busy_q, busy_d;
    logic              in_ready_c, accept_c, md_start_c;

`ifdef EXEC_MULDIV_EN
    logic              md_done_c;
    logic [DATA_W-1:0] md_lo_fin_c, hi_w, lo_w;

    muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
        .clk      (clockPulse),
        .rst_n    (resetN),
        .start    (md_start_c),
        .op_div   (ctrl_c == ALU_DIVU),
        .a        (bus.ALU_Read_DataOne),
        .b        (b_c),
        .done_c   (md_done_c),
        .lo_fin_c (md_lo_fin_c),
        .hi       (hi_w),
        .lo       (lo_w)
    );
`endif

    assign b_c     = bus.ALU_Source ? bus.Immediate : bus.ALU_Read_DataTwo;
    assign shamt_c = bus.Immediate[6+SHAMT_W-1:6];

    // ALU control decode
    always_comb begin
        ctrl_c = ALU_ZERO;
        case (bus.ALU_Operation)
            OP_ADD: ctrl_c = ALU_ADD;
            OP_SUB: ctrl_c = ALU_SUB;
            OP_AND: ctrl_c = ALU_AND;
            OP_OR:  ctrl_c = ALU_OR;
            OP_SLT: ctrl_c = ALU_SLT;
            OP_FUNC: begin
                case (bus.Function)
                    FN_ADD, FN_ADDU: ctrl_c = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl_c = ALU_SUB;
                    FN_AND:  ctrl_c = ALU_AND;
                    FN_OR:   ctrl_c = ALU_OR;
                    FN_XOR:  ctrl_c = ALU_XOR;
                    FN_NOR:  ctrl_c = ALU_NOR;
                    FN_SLT:  ctrl_c = ALU_SLT;
                    FN_SLTU: ctrl_c = ALU_SLTU;
                    FN_SLL:  ctrl_c = ALU_SLL;
                    FN_SRL:  ctrl_c = ALU_SRL;
                    FN_SRA:  ctrl_c = ALU_SRA;
`ifdef EXEC_MULDIV_EN
                    FN_MULTU: ctrl_c = ALU_MULTU;
                    FN_DIVU:  ctrl_c = ALU_DIVU;
                    FN_MFHI:  ctrl_c = ALU_MFHI;
                    FN_MFLO:  ctrl_c = ALU_MFLO;
`endif
                    default: ctrl_c = ALU_ZERO;
                endcase
            end
            default: ctrl_c = ALU_ZERO;
        endcase
    end

    // Single-cycle ALU
    always_comb begin
        alu_c = '0;
        case (ctrl_c)
            ALU_ADD:  alu_c = bus.ALU_Read_DataOne + b_c;
            ALU_SUB:  alu_c = bus.ALU_Read_DataOne - b_c;
            ALU_AND:  alu_c = bus.ALU_Read_DataOne & b_c;
            ALU_OR:   alu_c = bus.ALU_Read_DataOne | b_c;
            ALU_XOR:  alu_c = bus.ALU_Read_DataOne ^ b_c;
            ALU_NOR:  alu_c = ~(bus.ALU_Read_DataOne | b_c);
            ALU_SLT:  alu_c = DATA_W'($signed(bus.ALU_Read_DataOne) < $signed(b_c));
            ALU_SLTU: alu_c = DATA_W'(bus.ALU_Read_DataOne < b_c);
            ALU_SLL:  alu_c = b_c << shamt_c;
            ALU_SRL:  alu_c = b_c >> shamt_c;
            ALU_SRA:  alu_c = $unsigned($signed(b_c) >>> shamt_c);
`ifdef EXEC_MULDIV_EN
            ALU_MFHI: alu_c = hi_w;
            ALU_MFLO: alu_c = lo_w;
`endif
            default:  alu_c = '0;
        endcase
    end

    assign in_ready_c = (state_q == ST_IDLE) && (!valid_q || bus.Out_Ready);
    assign accept_c   = bus.In_Valid && in_ready_c;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        valid_d    = valid_q;
        busy_d     = 1'b0;
        md_start_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_q && bus.Out_Ready) valid_d = 1'b0;
                if (valid_q && !bus.Out_Ready) state_d = ST_HOLD;
                if (accept_c) begin
                    if (ctrl_c == ALU_MULTU || ctrl_c == ALU_DIVU) begin
                        md_start_c = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = (ctrl_c == ALU_DIVU) ? ST_DIV : ST_MUL;
                    end else begin
                        result_d = alu_c;
                        zero_d   = (alu_c == '0);
                        valid_d  = 1'b1;
                    end
                end
            end
`ifdef EXEC_MULDIV_EN
            ST_MUL, ST_DIV: begin
                busy_d = 1'b1;
                if (md_done_c) begin
                    result_d = md_lo_fin_c;
                    zero_d   = (md_lo_fin_c == '0);
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
`endif
            ST_HOLD: begin
                if (bus.Out_Ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clockPulse) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.In_Ready   = in_ready_c;
    assign bus.Out_Valid  = valid_q;
    assign bus.ALU_Result = result_q;
    assign bus.Zero       = zero_q;
    assign bus.Busy       = busy_q;

endmodule

// File: doc/execute_unit_mc.md
# execute_unit_mc

Parametrised multi-cycle execute stage for the pipelined datapath: selects the second operand (register or immediate), decodes ALU control from ALU_Operation/Function, and produces a registered result and Zero flag. Adds to single-cycle execution a DATA_W-cycle iterative unsigned multiply/divide with HI/LO registers, plus valid/ready handshakes on both sides so the unit can stall decode and be back-pressured by memory stage.

## Interface
- DATA_W, 32, operand/result width (≥8, power of two)
- SHAMT_W, $clog2(DATA_W), shift-amount width, taken from Immediate[6+SHAMT_W-1:6]
- clockPulse  in  1  clock, all state on rising edge
- resetN  in  1  reset, synchronous, active-low
- In_Valid  in  1  operands/controls valid
- In_Ready  out  1  unit can accept this cycle
- ALU_Read_DataOne  in  DATA_W  operand A
- ALU_Read_DataTwo  in  DATA_W  operand B (register)
- Immediate  in  DATA_W  sign-extended immediate
- Function  in  6  R-type function field
- ALU_Operation  in  3  main-control ALU op
- ALU_Source  in  1  0: operand B = ALU_Read_DataTwo, 1: Immediate
- Out_Valid  out  1  ALU_Result/Zero valid
- Out_Ready  in  1  downstream accepts
- ALU_Result  out  DATA_W  registered result
- Zero  out  1  ALU_Result == 0, registered with it
- Busy  out  1  multiply/divide in progress

## Operation
- ALU_Operation: 000 add, 001 sub, 010 decode Function, 011 and, 100 or, 101 slt (signed); 110/111 → result 0.
- Function (op 010): 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt signed, 0x2B sltu, 0x00 sll, 0x02 srl, 0x03 sra, 0x19 multu, 0x1B divu, 0x10 mfhi, 0x12 mflo; others → result 0.
- Shifts operate on operand B by shamt; add/sub wrap modulo 2^DATA_W, no overflow trap.
- States: IDLE, MUL, DIV, HOLD.
- IDLE + accept of single-cycle op → result registered, Out_Valid=1, state HOLD if Out_Ready low at next edge, else stays IDLE.
- IDLE + accept of multu/divu → MUL/DIV, counter loaded DATA_W, Busy=1.
- MUL: shift-add, one bit per cycle; DIV: restoring, one quotient bit per cycle. Counter 0 → HI/LO written (multu: HI=upper, LO=lower product; divu: HI=remainder, LO=quotient), ALU_Result=LO, Out_Valid=1, → HOLD/IDLE as above.
- divu by zero: still DATA_W cycles; LO=all ones, HI=dividend.
- mfhi/mflo: single-cycle, return HI/LO.
- HOLD: outputs stable until Out_Valid&&Out_Ready, then IDLE.
- In_Ready = (state==IDLE) && (!Out_Valid || Out_Ready): back-to-back single-cycle ops at one per cycle when downstream ready.
- In_Valid while In_Ready=0: ignored, upstream must hold.

## Timing
- Reset: Out_Valid=0, ALU_Result=0, Zero=1, Busy=0, HI=LO=0, state IDLE, counter 0. In_Ready=1 the first cycle after reset.
- Single-cycle op: Out_Valid one cycle after accept.
- multu/divu: Out_Valid DATA_W+1 cycles after accept; Busy high on cycles 1..DATA_W.
- resetN low mid-operation: abort at that edge, HI/LO cleared, no Out_Valid.
- Out_Ready low at completion: result held, no new accept.

## Configuration
- EXEC_MULDIV_EN defined: multiplier/divider, HI/LO, MUL/DIV states built as above.
- Undefined: multu/divu/mfhi/mflo decode as unknown (result 0, single-cycle); Busy tied 0; no HI/LO storage.

## Structure
- Package exec_pkg: ALU_Operation codes, Function codes, internal ALU control enum, state enum.
- Sub-module muldiv_iter: iterative multiply/divide datapath, start/op/done interface, HI/LO outputs; instantiated only under EXEC_MULDIV_EN.
- Operand mux, ALU control decode and ALU combinational in top.

## Test plan
- Reset then op 000, A=5, Immediate=0xFFFFFFFB, ALU_Source=1 → next cycle Out_Valid=1, result 0, Zero=1.
- Function 0x03, B=0x80000000, shamt=4 → 0xF8000000; 0x2A A=-1 B=1 → 1; 0x2B same → 0.
- multu 0xFFFFFFFF×2, then mflo/mfhi → LO=0xFFFFFFFE at cycle 33, HI=1; In_Ready low for 33 cycles.
- divu 100/7 → LO=14 and HI=2; divu 9/0 → LO=0xFFFFFFFF, HI=9.
- Out_Ready held low 3 cycles after add result → result/Zero stable, In_Ready=0, next op accepted on release.
- resetN low at cycle 10 of multu → Busy=0, HI=LO=0, no Out_Valid.
